// File: rtl/acb_arbiter.sv
// ---------------------------------------------------------------------------
// acb_arbiter
//
// Purpose:
//   Shares a single ACB (GF(2^163) multiply/divide unit) between two
//   requesters. A round-robin pointer breaks ties when both requesters ask
//   in the same cycle. The winner's operands and mode are latched and held
//   on the ACB for the whole operation. The ACB result is then returned to
//   the winner with a one-cycle response pulse.
//
// Optional feature (macro ACB_ARB_TIMEOUT_EN):
//   Defined   : a watchdog aborts an operation that runs for TIMEOUT_CYCLES
//               RUN cycles without acb_done. The abort pulses rsp_err together
//               with rsp_valid of the owning requester.
//   Undefined : no watchdog is built, rsp_err is constant 0, and RUN waits
//               for acb_done indefinitely.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req0/cfg0/a0/b0       requester 0 request (level), mode, operands
//   gnt0, rsp_valid0      requester 0 grant pulse, result-valid pulse
//   req1/cfg1/a1/b1       requester 1 request (level), mode, operands
//   gnt1, rsp_valid1      requester 1 grant pulse, result-valid pulse
//   rsp_c                 result of the most recent operation (shared)
//   rsp_err               watchdog abort pulse
//   acb_enable            ACB enable, held for the whole operation
//   acb_configuration     ACB mode (0 = multiply, 1 = divide)
//   acb_a, acb_b          ACB operands
//   acb_c, acb_done       ACB result; done pulse, with acb_c valid that cycle
//   busy                  high whenever the arbiter is not idle
//   op_count              number of completed operations (wraps)
// ---------------------------------------------------------------------------
module acb_arbiter #(
  parameter int WIDTH          = 163,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             cfg0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             rsp_valid0,
  input  logic             req1,
  input  logic             cfg1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_err,
  output logic             acb_enable,
  output logic             acb_configuration,
  output logic [WIDTH-1:0] acb_a,
  output logic [WIDTH-1:0] acb_b,
  input  logic [WIDTH-1:0] acb_c,
  input  logic             acb_done,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state, w_stateNext;
  logic             r_gnt0, w_gnt0;
  logic             r_gnt1, w_gnt1;
  logic             r_rspValid0, w_rspValid0;
  logic             r_rspValid1, w_rspValid1;
  logic [WIDTH-1:0] r_rspC, w_rspC;
  logic             r_acbEnable, w_acbEnable;
  logic             r_acbCfg, w_acbCfg;
  logic [WIDTH-1:0] r_acbA, w_acbA;
  logic [WIDTH-1:0] r_acbB, w_acbB;
  logic             r_busy, w_busy;
  logic [15:0]      r_opCount, w_opCount;
  logic             r_ptr, w_ptr;
  logic             r_id, w_id;
  logic             w_winner;

`ifdef ACB_ARB_TIMEOUT_EN
  localparam logic [10:0] TIMEOUT_LIMIT = 11'(TIMEOUT_CYCLES - 1);
  logic [10:0]      r_timer, w_timer;
  logic             r_rspErr, w_rspErr;
`endif

  // Next-state and next-output logic. Every registered output is computed
  // here so the sequential block below is a plain register bank.
  always_comb begin
    w_stateNext = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_rspValid0 = 1'b0;
    w_rspValid1 = 1'b0;
    w_rspC      = r_rspC;
    w_acbEnable = r_acbEnable;
    w_acbCfg    = r_acbCfg;
    w_acbA      = r_acbA;
    w_acbB      = r_acbB;
    w_opCount   = r_opCount;
    w_ptr       = r_ptr;
    w_id        = r_id;
    w_winner    = 1'b0;
`ifdef ACB_ARB_TIMEOUT_EN
    w_timer     = r_timer;
    w_rspErr    = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          // A lone request wins outright; a tie goes to the pointer.
          w_winner    = (req0 && req1) ? r_ptr : req1;
          w_id        = w_winner;
          w_gnt0      = ~w_winner;
          w_gnt1      = w_winner;
          w_acbEnable = 1'b1;
          w_acbCfg    = w_winner ? cfg1 : cfg0;
          w_acbA      = w_winner ? a1 : a0;
          w_acbB      = w_winner ? b1 : b0;
`ifdef ACB_ARB_TIMEOUT_EN
          w_timer     = '0;
`endif
          w_stateNext = RUN;
        end
      end

      RUN: begin
        // Done has priority over a watchdog expiry in the same cycle.
        if (acb_done) begin
          w_rspC      = acb_c;
          w_acbEnable = 1'b0;
          w_acbCfg    = 1'b0;
          w_acbA      = '0;
          w_acbB      = '0;
          w_rspValid0 = ~r_id;
          w_rspValid1 = r_id;
          w_opCount   = r_opCount + 16'd1;
          w_ptr       = ~r_id;
          w_stateNext = RESP;
        end
`ifdef ACB_ARB_TIMEOUT_EN
        else if (r_timer == TIMEOUT_LIMIT) begin
          w_rspC      = '0;
          w_acbEnable = 1'b0;
          w_acbCfg    = 1'b0;
          w_acbA      = '0;
          w_acbB      = '0;
          w_rspValid0 = ~r_id;
          w_rspValid1 = r_id;
          w_rspErr    = 1'b1;
          w_ptr       = ~r_id;
          w_stateNext = RESP;
        end else begin
          w_timer     = r_timer + 11'd1;
        end
`endif
      end

      // One dead cycle with the enable low so the ACB rearms.
      RESP: begin
        w_stateNext = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase

    w_busy = (w_stateNext != IDLE);
  end

  // State and output register bank; reset clears everything, aborting any
  // operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rspValid0 <= 1'b0;
      r_rspValid1 <= 1'b0;
      r_rspC      <= '0;
      r_acbEnable <= 1'b0;
      r_acbCfg    <= 1'b0;
      r_acbA      <= '0;
      r_acbB      <= '0;
      r_busy      <= 1'b0;
      r_opCount   <= '0;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
`ifdef ACB_ARB_TIMEOUT_EN
      r_timer     <= '0;
      r_rspErr    <= 1'b0;
`endif
    end else begin
      r_state     <= w_stateNext;
      r_gnt0      <= w_gnt0;
      r_gnt1      <= w_gnt1;
      r_rspValid0 <= w_rspValid0;
      r_rspValid1 <= w_rspValid1;
      r_rspC      <= w_rspC;
      r_acbEnable <= w_acbEnable;
      r_acbCfg    <= w_acbCfg;
      r_acbA      <= w_acbA;
      r_acbB      <= w_acbB;
      r_busy      <= w_busy;
      r_opCount   <= w_opCount;
      r_ptr       <= w_ptr;
      r_id        <= w_id;
`ifdef ACB_ARB_TIMEOUT_EN
      r_timer     <= w_timer;
      r_rspErr    <= w_rspErr;
`endif
    end
  end

  assign gnt0              = r_gnt0;
  assign gnt1              = r_gnt1;
  assign rsp_valid0        = r_rspValid0;
  assign rsp_valid1        = r_rspValid1;
  assign rsp_c             = r_rspC;
  assign acb_enable        = r_acbEnable;
  assign acb_configuration = r_acbCfg;
  assign acb_a             = r_acbA;
  assign acb_b             = r_acbB;
  assign busy              = r_busy;
  assign op_count          = r_opCount;
`ifdef ACB_ARB_TIMEOUT_EN
  assign rsp_err           = r_rspErr;
`else
  assign rsp_err           = 1'b0;
`endif

endmodule

// File: tb/tb_acb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_acb_arbiter
//
// Purpose:
//   Directed test of acb_arbiter against a behavioural ACB model
//   (5-cycle latency; C = A ^ B in mode 0, C = A in mode 1). Expected
//   responses are queued when each request is issued. A monitor pops and
//   compares them whenever the arbiter presents a response.
//   Define ACB_ARB_TIMEOUT_EN to also exercise the watchdog (limit 8).
// ---------------------------------------------------------------------------
module tb_acb_arbiter;

  localparam int W = 163;
`ifdef ACB_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 1023;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, cfg0 = 1'b0, req1 = 1'b0, cfg1 = 1'b0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err;
  logic [W-1:0]  rsp_c, acb_a, acb_b;
  logic          acb_enable, acb_configuration, busy;
  logic [15:0]   op_count;
  logic [W-1:0]  acb_c = '0;
  logic          acb_done = 1'b0;
  logic          noDone = 1'b0;
  int            mCnt = 0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] c;
    logic         err;
    logic [15:0]  cnt;
  } exp_t;
  exp_t expQ[$];

  acb_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cfg0(cfg0), .a0(a0), .b0(b0), .gnt0(gnt0), .rsp_valid0(rsp_valid0),
    .req1(req1), .cfg1(cfg1), .a1(a1), .b1(b1), .gnt1(gnt1), .rsp_valid1(rsp_valid1),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .acb_enable(acb_enable), .acb_configuration(acb_configuration),
    .acb_a(acb_a), .acb_b(acb_b), .acb_c(acb_c), .acb_done(acb_done),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ACB model: done is raised in the 6th enabled cycle, 5 cycles after the
  // enable rises; noDone suppresses it for the watchdog test.
  always @(posedge clk or posedge rst) begin
    if (rst || !acb_enable) begin
      mCnt     <= 0;
      acb_done <= 1'b0;
    end else begin
      mCnt     <= mCnt + 1;
      acb_done <= (mCnt == 4) && !noDone;
      acb_c    <= acb_configuration ? acb_a : (acb_a ^ acb_b);
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (rsp_valid0 || rsp_valid1 || rsp_err)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResp: got v0=%0b v1=%0b err=%0b expected none",
                 rsp_valid0, rsp_valid1, rsp_err);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rspValid0", W'(rsp_valid0), W'(!e.id));
        checkOutput("rspValid1", W'(rsp_valid1), W'(e.id));
        checkOutput("rspC", rsp_c, e.c);
        checkOutput("rspErr", W'(rsp_err), W'(e.err));
        checkOutput("opCount", W'(op_count), W'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic which, input logic cfg,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    if (which) begin
      req1 = 1'b1; cfg1 = cfg; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; cfg0 = cfg; a0 = a; b0 = b;
    end
  endtask

  task automatic pushExp(input logic id, input logic [W-1:0] c, input logic err, input logic [15:0] cnt);
    exp_t e;
    e.id = id; e.c = c; e.err = err; e.cnt = cnt;
    expQ.push_back(e);
  endtask

  // Called one cycle after the request was raised.
  task automatic checkGrant(input logic id, input logic cfg, input logic [W-1:0] a, input logic [W-1:0] b);
    checkOutput("gnt0", W'(gnt0), W'(!id));
    checkOutput("gnt1", W'(gnt1), W'(id));
    checkOutput("grantEnable", W'(acb_enable), W'(1'b1));
    checkOutput("grantCfg", W'(acb_configuration), W'(cfg));
    checkOutput("grantA", acb_a, a);
    checkOutput("grantB", acb_b, b);
    checkOutput("grantBusy", W'(busy), W'(1'b1));
  endtask

  // Waits (bounded) for a response pulse, checks its distance from the
  // grant cycle, then checks the arbiter is idle on the following cycle.
  task automatic waitResp(input string name, input int expLat);
    int k;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (rsp_valid0 || rsp_valid1 || rsp_err) break;
    end
    checkOutput(name, W'(k), W'(expLat));
    checkOutput("respEnableLow", W'(acb_enable), W'(1'b0));
    tick();
    checkOutput("idleBusy", W'(busy), W'(1'b0));
    checkOutput("idleAcbA", acb_a, '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int nG;
    int gOrder[3];
    int gCyc[3];
    int rsp0Cyc;

    // Reset state
    doReset();
    checkOutput("rstBusy", W'(busy), '0);
    checkOutput("rstEnable", W'(acb_enable), '0);
    checkOutput("rstRspC", rsp_c, '0);
    checkOutput("rstOpCount", W'(op_count), '0);
    checkOutput("rstGnt", W'({gnt0, gnt1, rsp_valid0, rsp_valid1}), '0);

    // Single request: 5 ^ 3 = 6
    applyStimulus(1'b0, 1'b0, W'(163'h5), W'(163'h3));
    pushExp(1'b0, W'(163'h6), 1'b0, 16'd1);
    tick();
    checkGrant(1'b0, 1'b0, W'(163'h5), W'(163'h3));
    req0 = 1'b0;
    tick();
    checkOutput("gnt0Pulse", W'(gnt0), '0);
    checkOutput("enableHeld", W'(acb_enable), W'(1'b1));
    waitResp("singleLatency", 5);

    // Simultaneous requests after reset: service order 0, 1, 0
    doReset();
    applyStimulus(1'b0, 1'b0, W'(163'h1), W'(163'h2));
    applyStimulus(1'b1, 1'b0, W'(163'h8), W'(163'h1));
    pushExp(1'b0, W'(163'h3), 1'b0, 16'd1);
    pushExp(1'b1, W'(163'h9), 1'b0, 16'd2);
    pushExp(1'b0, W'(163'h3), 1'b0, 16'd3);
    nG = 0;
    rsp0Cyc = 0;
    for (int k = 1; k <= 60 && nG < 3; k++) begin
      tick();
      if (rsp_valid0 && rsp0Cyc == 0) rsp0Cyc = k;
      if (gnt0 || gnt1) begin
        gOrder[nG] = gnt1 ? 1 : 0;
        gCyc[nG]   = k;
        nG++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("grantCount", W'(nG), W'(3));
    if (nG == 3) begin
      checkOutput("order0", W'(gOrder[0]), W'(0));
      checkOutput("order1", W'(gOrder[1]), W'(1));
      checkOutput("order2", W'(gOrder[2]), W'(0));
      checkOutput("gnt1AfterRsp0", W'(gCyc[1] - rsp0Cyc), W'(2));
    end
    tick();
    waitResp("tieLatency", 5);

    // Configuration pass-through: divide mode returns A
    applyStimulus(1'b1, 1'b1, W'(163'hABC), W'(163'h123));
    pushExp(1'b1, W'(163'hABC), 1'b0, 16'd4);
    tick();
    checkGrant(1'b1, 1'b1, W'(163'hABC), W'(163'h123));
    req1 = 1'b0;
    tick();
    checkOutput("cfgHeld", W'(acb_configuration), W'(1'b1));
    waitResp("cfgLatency", 5);

    // Operand stability: 0x30 ^ 0x0F = 0x3F despite a0 changing
    applyStimulus(1'b0, 1'b0, W'(163'h30), W'(163'h0F));
    pushExp(1'b0, W'(163'h3F), 1'b0, 16'd5);
    tick();
    checkGrant(1'b0, 1'b0, W'(163'h30), W'(163'h0F));
    tick();
    a0 = W'(163'hFFFF);
    req0 = 1'b0;
    tick();
    checkOutput("stableA", acb_a, W'(163'h30));
    checkOutput("stableB", acb_b, W'(163'h0F));
    waitResp("stableLatency", 4);

    // Reset three cycles into RUN aborts with no response
    applyStimulus(1'b0, 1'b0, W'(163'h1), W'(163'h1));
    tick();
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abortEnable", W'(acb_enable), '0);
    checkOutput("abortBusy", W'(busy), '0);
    checkOutput("abortA", acb_a, '0);
    checkOutput("abortRspC", rsp_c, '0);
    checkOutput("abortOpCount", W'(op_count), '0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, W'(163'h55), W'(163'hF0));
    pushExp(1'b1, W'(163'hA5), 1'b0, 16'd1);
    tick();
    checkGrant(1'b1, 1'b0, W'(163'h55), W'(163'hF0));
    req1 = 1'b0;
    waitResp("postResetLatency", 6);

`ifdef ACB_ARB_TIMEOUT_EN
    // Watchdog: no done -> error response, rsp_c cleared, count unchanged
    noDone = 1'b1;
    applyStimulus(1'b0, 1'b0, W'(163'h7), W'(163'h1));
    pushExp(1'b0, '0, 1'b1, 16'd1);
    tick();
    checkGrant(1'b0, 1'b0, W'(163'h7), W'(163'h1));
    req0 = 1'b0;
    waitResp("timeoutLatency", 8);
    noDone = 1'b0;
    applyStimulus(1'b0, 1'b0, W'(163'h10), W'(163'h01));
    pushExp(1'b0, W'(163'h11), 1'b0, 16'd2);
    tick();
    checkGrant(1'b0, 1'b0, W'(163'h10), W'(163'h01));
    req0 = 1'b0;
    waitResp("afterTimeoutLatency", 6);
`endif

    tick();
    checkOutput("outstandingResp", W'(expQ.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
